// File: rtl/cae_v2_pkg.sv
// Shared types and default widths for the conflict-analysis engine.
package satswarmv2_pkg;

   localparam int CAE_MAX_LITS = 8;
   localparam int CAE_LEVEL_W  = 8;
   localparam int CAE_LIT_W    = 32;

   typedef enum logic [1:0] {
      CAE_IDLE,
      CAE_SCAN,
      CAE_EMIT
   } cae_state_e;

endpackage

// File: rtl/cae_v2_if.sv
// Request/result bundle between the solver core (master) and the analysis engine (slave).
interface cae_v2_if #(
   parameter int MAX_LITS = satswarmv2_pkg::CAE_MAX_LITS,
   parameter int LEVEL_W  = satswarmv2_pkg::CAE_LEVEL_W,
   parameter int LIT_W    = satswarmv2_pkg::CAE_LIT_W,
   parameter int LEN_W    = $clog2(MAX_LITS + 1)
);
   logic                                start;
   logic                                busy;
   logic [LEVEL_W-1:0]                  decision_level;
   logic [LEN_W-1:0]                    conflict_len;
   logic signed [MAX_LITS-1:0][LIT_W-1:0]   conflict_lits;
   logic [MAX_LITS-1:0][LEVEL_W-1:0]    conflict_levels;
   logic                                learned_valid;
   logic                                learned_ready;
   logic [LEN_W-1:0]                    learned_len;
   logic signed [MAX_LITS-1:0][LIT_W-1:0]   learned_clause;
   logic [LEVEL_W-1:0]                  backtrack_level;
   logic                                unsat;
   logic                                done;

   modport master (
      output start, decision_level, conflict_len, conflict_lits, conflict_levels, learned_ready,
      input  busy, learned_valid, learned_len, learned_clause, backtrack_level, unsat, done
   );

   modport slave (
      input  start, decision_level, conflict_len, conflict_lits, conflict_levels, learned_ready,
      output busy, learned_valid, learned_len, learned_clause, backtrack_level, unsat, done
   );
endinterface

// File: rtl/cae_v2.sv
// 1-UIP style conflict analysis: one literal per SCAN cycle, result committed conflict_len+1 cycles after start.
// Result held under learned_valid until learned_ready; CAE_V2_DEDUP_EN drops repeated literals during SCAN.
module cae_v2
   import satswarmv2_pkg::*;
#(
   parameter int MAX_LITS = CAE_MAX_LITS,
   parameter int LEVEL_W  = CAE_LEVEL_W,
   parameter int LIT_W    = CAE_LIT_W,
   parameter int LEN_W    = $clog2(MAX_LITS + 1)
) (
   input logic     clk,
   input logic     reset,
   cae_v2_if.slave bus
);
   localparam int IDX_W = (MAX_LITS > 1) ? $clog2(MAX_LITS) : 1;

   cae_state_e                       state_q, state_d;
   logic                             armed_q, armed_d;
   logic [LEVEL_W-1:0]               dl_q, dl_d;
   logic [LEN_W-1:0]                 len_q, len_d, idx_q, idx_d;
   logic [MAX_LITS-1:0][LIT_W-1:0]   lits_q, lits_d;
   logic [MAX_LITS-1:0][LEVEL_W-1:0] lvls_q, lvls_d;
   logic [MAX_LITS-1:0]              keep_q, keep_d;
   logic [IDX_W-1:0]                 uip_q, uip_d;
   logic [LEVEL_W-1:0]               max1_q, max1_d, max2_q, max2_d;
   logic                             valid_q, valid_d, done_q, done_d, unsat_q, unsat_d;
   logic [LEN_W-1:0]                 out_len_q, out_len_d;
   logic [MAX_LITS-1:0][LIT_W-1:0]   clause_q, clause_d;
   logic [LEVEL_W-1:0]               bt_q, bt_d;

   logic                             accept, last, dup;
   logic [LEN_W-1:0]                 len_sat, cnt_n;
   logic [IDX_W-1:0]                 cur;
   logic [LEVEL_W-1:0]               cur_lvl;
   logic [MAX_LITS-1:0][LIT_W-1:0]   clause_n;

   assign accept  = (state_q == CAE_IDLE) && bus.start && armed_q;
   assign last    = (state_q == CAE_SCAN) && (idx_q == len_q - LEN_W'(1));
   assign cur     = idx_q[IDX_W-1:0];
   assign cur_lvl = lvls_q[cur];
   assign len_sat = (bus.conflict_len > LEN_W'(MAX_LITS)) ? LEN_W'(MAX_LITS) : bus.conflict_len;

`ifdef CAE_V2_DEDUP_EN
   always_comb begin
      dup = 1'b0;
      for (int j = 0; j < MAX_LITS; j++) begin
         if ((LEN_W'(j) < idx_q) && (lits_q[j] == lits_q[cur])) dup = 1'b1;
      end
   end
`else
   assign dup = 1'b0;
`endif

   // Tracking: first strictly-greater level wins the UIP slot, so ties keep the earlier index.
   always_comb begin
      idx_d  = idx_q;
      keep_d = keep_q;
      uip_d  = uip_q;
      max1_d = max1_q;
      max2_d = max2_q;
      if (accept) begin
         idx_d  = '0;
         keep_d = '0;
         uip_d  = '0;
         max1_d = '0;
         max2_d = '0;
      end else if (state_q == CAE_SCAN) begin
         idx_d = idx_q + LEN_W'(1);
         if (!dup) begin
            keep_d[cur] = 1'b1;
            if (cur_lvl > max1_q) begin
               max2_d = max1_q;
               max1_d = cur_lvl;
               uip_d  = cur;
            end else if (cur_lvl > max2_q) begin
               max2_d = cur_lvl;
            end
         end
      end
   end

   // Compaction of the kept literals behind the UIP, preserving original order.
   always_comb begin
      clause_n    = '0;
      cnt_n       = LEN_W'(1);
      clause_n[0] = lits_q[uip_d];
      for (int i = 0; i < MAX_LITS; i++) begin
         if (keep_d[i] && (IDX_W'(i) != uip_d)) begin
            clause_n[cnt_n[IDX_W-1:0]] = lits_q[i];
            cnt_n = cnt_n + LEN_W'(1);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      armed_d   = 1'b1;
      dl_d      = dl_q;
      len_d     = len_q;
      lits_d    = lits_q;
      lvls_d    = lvls_q;
      valid_d   = valid_q;
      done_d    = 1'b0;
      unsat_d   = unsat_q;
      out_len_d = out_len_q;
      clause_d  = clause_q;
      bt_d      = bt_q;
      case (state_q)
         CAE_IDLE: begin
            if (accept) begin
               dl_d    = bus.decision_level;
               len_d   = len_sat;
               lits_d  = bus.conflict_lits;
               unsat_d = 1'b0;
               for (int i = 0; i < MAX_LITS; i++) begin
                  lvls_d[i] = (bus.conflict_levels[i] > bus.decision_level) ?
                              bus.decision_level : bus.conflict_levels[i];
               end
               if (len_sat == '0) begin
                  state_d   = CAE_EMIT;
                  done_d    = 1'b1;
                  unsat_d   = 1'b1;
                  valid_d   = 1'b0;
                  out_len_d = '0;
                  clause_d  = '0;
                  bt_d      = '0;
               end else begin
                  state_d = CAE_SCAN;
               end
            end
         end
         CAE_SCAN: begin
            if (last) begin
               state_d = CAE_EMIT;
               done_d  = 1'b1;
               if ((max1_d == '0) || (dl_q == '0)) begin
                  unsat_d   = 1'b1;
                  valid_d   = 1'b0;
                  out_len_d = '0;
                  clause_d  = '0;
                  bt_d      = '0;
               end else begin
                  valid_d   = 1'b1;
                  out_len_d = cnt_n;
                  clause_d  = clause_n;
                  bt_d      = max2_d;
               end
            end
         end
         CAE_EMIT: begin
            if (unsat_q) begin
               state_d = CAE_IDLE;
            end else if (valid_q && bus.learned_ready) begin
               valid_d = 1'b0;
               state_d = CAE_IDLE;
            end
         end
         default: state_d = CAE_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= CAE_IDLE;
         armed_q   <= 1'b0;
         dl_q      <= '0;
         len_q     <= '0;
         idx_q     <= '0;
         lits_q    <= '0;
         lvls_q    <= '0;
         keep_q    <= '0;
         uip_q     <= '0;
         max1_q    <= '0;
         max2_q    <= '0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
         unsat_q   <= 1'b0;
         out_len_q <= '0;
         clause_q  <= '0;
         bt_q      <= '0;
      end else begin
         state_q   <= state_d;
         armed_q   <= armed_d;
         dl_q      <= dl_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         lits_q    <= lits_d;
         lvls_q    <= lvls_d;
         keep_q    <= keep_d;
         uip_q     <= uip_d;
         max1_q    <= max1_d;
         max2_q    <= max2_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
         unsat_q   <= unsat_d;
         out_len_q <= out_len_d;
         clause_q  <= clause_d;
         bt_q      <= bt_d;
      end
   end

   assign bus.busy            = (state_q != CAE_IDLE);
   assign bus.learned_valid   = valid_q;
   assign bus.done            = done_q;
   assign bus.unsat           = unsat_q;
   assign bus.learned_len     = out_len_q;
   assign bus.learned_clause  = clause_q;
   assign bus.backtrack_level = bt_q;

endmodule

// File: tb/tb_cae_v2.sv
// Directed vector table plus hand-written stall and reset sequences for cae_v2.
module tb_cae_v2;
   typedef int arr8_t [8];

   typedef struct {
      logic [3:0]        len;
      logic [7:0]        dl;
      logic [7:0][31:0]  lits;
      logic [7:0][7:0]   lvls;
      logic [3:0]        exp_len;
      logic [7:0][31:0]  exp_clause;
      logic [7:0]        exp_bt;
      logic              exp_unsat;
      int                exp_cyc;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];

   cae_v2_if #(.MAX_LITS(8), .LEVEL_W(8), .LIT_W(32)) bus ();

   cae_v2 #(.MAX_LITS(8), .LEVEL_W(8), .LIT_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic void add(input int len, input int dl, input arr8_t lit, input arr8_t lvl,
                               input int elen, input arr8_t ecl, input int ebt, input bit eunsat);
      vec_t v;
      v.len = len[3:0];
      v.dl  = dl[7:0];
      for (int k = 0; k < 8; k++) begin
         v.lits[k]       = lit[k];
         v.lvls[k]       = lvl[k][7:0];
         v.exp_clause[k] = ecl[k];
      end
      v.exp_len   = elen[3:0];
      v.exp_bt    = ebt[7:0];
      v.exp_unsat = eunsat;
      v.exp_cyc   = ((len > 8) ? 8 : len) + 1;
      vecs.push_back(v);
   endfunction

   task automatic drive(input vec_t v);
      bus.conflict_len    = v.len;
      bus.decision_level  = v.dl;
      bus.conflict_lits   = v.lits;
      bus.conflict_levels = v.lvls;
   endtask

   // Starts a vector and returns the number of edges from the accepting edge until done is seen.
   task automatic wait_done(output int n, output bit got);
      n = 0;
      got = 1'b0;
      while (n < 40 && !got) begin
         @(posedge clk);
         #1;
         n++;
         bus.start = 1'b0;
         if (bus.done) got = 1'b1;
      end
   endtask

   task automatic run_vec(input vec_t v, input int k);
      int n;
      bit got;
      @(negedge clk);
      drive(v);
      bus.learned_ready = 1'b1;
      bus.start = 1'b1;
      wait_done(n, got);
      chk($sformatf("v%0d_done_seen", k), got, 1);
      chk($sformatf("v%0d_latency", k), n, v.exp_cyc);
      chk($sformatf("v%0d_busy_emit", k), bus.busy, 1);
      chk($sformatf("v%0d_valid", k), bus.learned_valid, !v.exp_unsat);
      chk($sformatf("v%0d_unsat", k), bus.unsat, v.exp_unsat);
      chk($sformatf("v%0d_len", k), bus.learned_len, v.exp_len);
      if (!v.exp_unsat) begin
         chk($sformatf("v%0d_clause", k), bus.learned_clause, v.exp_clause);
         chk($sformatf("v%0d_bt", k), bus.backtrack_level, v.exp_bt);
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_busy_after", k), bus.busy, 0);
      chk($sformatf("v%0d_done_pulse", k), bus.done, 0);
      chk($sformatf("v%0d_valid_after", k), bus.learned_valid, 0);
      chk($sformatf("v%0d_unsat_held", k), bus.unsat, v.exp_unsat);
      chk($sformatf("v%0d_len_held", k), bus.learned_len, v.exp_len);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_busy"}, bus.busy, 0);
      chk({nm, "_valid"}, bus.learned_valid, 0);
      chk({nm, "_done"}, bus.done, 0);
      chk({nm, "_unsat"}, bus.unsat, 0);
      chk({nm, "_len"}, bus.learned_len, 0);
      chk({nm, "_clause"}, bus.learned_clause, 0);
      chk({nm, "_bt"}, bus.backtrack_level, 0);
   endtask

   initial begin
      int n;
      bit got;
      bus.start = 1'b0;
      bus.learned_ready = 1'b0;
      bus.conflict_len = '0;
      bus.decision_level = '0;
      bus.conflict_lits = '0;
      bus.conflict_levels = '0;

      add(3, 5, '{10,11,12,0,0,0,0,0}, '{5,3,2,0,0,0,0,0}, 3, '{10,11,12,0,0,0,0,0}, 3, 0);
      add(3, 4, '{20,21,22,0,0,0,0,0}, '{2,4,1,0,0,0,0,0}, 3, '{21,20,22,0,0,0,0,0}, 2, 0);
      add(2, 0, '{5,6,0,0,0,0,0,0},    '{0,0,0,0,0,0,0,0}, 0, '{0,0,0,0,0,0,0,0},    0, 1);
      add(2, 6, '{30,31,0,0,0,0,0,0},  '{9,7,0,0,0,0,0,0}, 2, '{30,31,0,0,0,0,0,0},  6, 0);
      add(0, 5, '{1,2,0,0,0,0,0,0},    '{3,3,0,0,0,0,0,0}, 0, '{0,0,0,0,0,0,0,0},    0, 1);
      add(1, 4, '{50,0,0,0,0,0,0,0},   '{4,0,0,0,0,0,0,0}, 1, '{50,0,0,0,0,0,0,0},   0, 0);
      add(1, 0, '{40,0,0,0,0,0,0,0},   '{3,0,0,0,0,0,0,0}, 0, '{0,0,0,0,0,0,0,0},    0, 1);
      add(2, 3, '{60,61,0,0,0,0,0,0},  '{0,0,0,0,0,0,0,0}, 0, '{0,0,0,0,0,0,0,0},    0, 1);
      add(9, 7, '{100,101,102,103,104,105,106,107}, '{1,2,3,7,5,4,2,1},
          8, '{103,100,101,102,104,105,106,107}, 5, 0);
      add(3, 2, '{-3,-5,4,0,0,0,0,0},  '{2,2,1,0,0,0,0,0}, 3, '{-3,-5,4,0,0,0,0,0},  2, 0);
`ifdef CAE_V2_DEDUP_EN
      add(3, 3, '{7,7,8,0,0,0,0,0},    '{3,3,1,0,0,0,0,0}, 2, '{7,8,0,0,0,0,0,0},    1, 0);
`else
      add(3, 3, '{7,7,8,0,0,0,0,0},    '{3,3,1,0,0,0,0,0}, 3, '{7,7,8,0,0,0,0,0},    3, 0);
`endif

      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

      // Stall: result must hold and a new start must be ignored while learned_ready is low.
      @(negedge clk);
      drive(vecs[0]);
      bus.learned_ready = 1'b0;
      bus.start = 1'b1;
      wait_done(n, got);
      chk("stall_latency", n, 4);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         bus.start = 1'b1;
         bus.conflict_len = 4'd1;
         bus.conflict_lits[0] = 32'd99;
         @(posedge clk);
         #1;
         chk($sformatf("stall%0d_valid", c), bus.learned_valid, 1);
         chk($sformatf("stall%0d_busy", c), bus.busy, 1);
         chk($sformatf("stall%0d_done", c), bus.done, 0);
         chk($sformatf("stall%0d_clause", c), bus.learned_clause, vecs[0].exp_clause);
         chk($sformatf("stall%0d_len", c), bus.learned_len, 3);
         chk($sformatf("stall%0d_bt", c), bus.backtrack_level, 3);
      end
      @(negedge clk);
      bus.start = 1'b0;
      bus.learned_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("stall_release_busy", bus.busy, 0);
      chk("stall_release_valid", bus.learned_valid, 0);
      chk("stall_idle_clause", bus.learned_clause, vecs[0].exp_clause);
      @(posedge clk);
      #1;
      chk("stall_start_dropped", bus.busy, 0);

      // Reset in the middle of SCAN, then start in the first cycle after release is ignored.
      @(negedge clk);
      drive(vecs[1]);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      chk("midscan_busy", bus.busy, 1);
      #2;
      reset = 1'b1;
      #1;
      chk_zero("midscan_reset");
      @(negedge clk);
      reset = 1'b0;
      drive(vecs[0]);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      chk("post_reset_start_ignored", bus.busy, 0);
      bus.start = 1'b0;
      run_vec(vecs[0], 100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cae_v2.md
CAE_V2 -- requirements
Module: cae_v2

Interface
REQ-001 SHALL have parameter MAX_LITS, default 8: maximum literals per conflict clause.
REQ-002 SHALL have parameter LEVEL_W, default 8: decision-level width.
REQ-003 SHALL have parameter LIT_W, default 32: signed literal width.
REQ-004 SHALL have parameter LEN_W, default $clog2(MAX_LITS+1): clause-length width.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: request analysis; sampled only in IDLE.
REQ-008 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-009 SHALL have port decision_level, input, LEVEL_W: current solver level, captured on start.
REQ-010 SHALL have port conflict_len, input, LEN_W: valid literal count.
REQ-011 SHALL have port conflict_lits, input, MAX_LITS x LIT_W signed: conflict literals.
REQ-012 SHALL have port conflict_levels, input, MAX_LITS x LEVEL_W: assignment level per literal.
REQ-013 SHALL have port learned_valid, output, 1: learned-clause handshake valid.
REQ-014 SHALL have port learned_ready, input, 1: consumer accepts the learned clause.
REQ-015 SHALL have port learned_len, output, LEN_W: learned-clause literal count.
REQ-016 SHALL have port learned_clause, output, MAX_LITS x LIT_W signed: learned literals, UIP at index 0.
REQ-017 SHALL have port backtrack_level, output, LEVEL_W: non-chronological backtrack target.
REQ-018 SHALL have port unsat, output, 1: level-0 conflict, held until next accepted start.
REQ-019 SHALL have port done, output, 1: one-cycle pulse when the result is committed.

Function
REQ-020 SHALL implement FSM IDLE -> SCAN -> EMIT -> IDLE; start is ignored in SCAN and EMIT.
REQ-021 SHALL, on start in IDLE, register all inputs; conflict_len > MAX_LITS saturates to MAX_LITS.
REQ-022 SHALL process one literal per cycle in SCAN, i.e. SCAN lasts exactly conflict_len cycles.
REQ-023 SHALL select as UIP the lowest-index literal with maximum level; ties keep the earlier index.
REQ-024 SHALL set backtrack_level to the maximum level among non-UIP literals, or 0 if no non-UIP literals remain.
REQ-025 SHALL emit learned_clause with the UIP at index 0 and other literals in original order; literal values are unchanged; unused slots are zero.
REQ-026 SHALL declare unsat when the maximum level is 0, decision_level is 0, or conflict_len is 0.
REQ-027 SHALL, on unsat, pulse done on entry to EMIT, keep learned_valid low, and return to IDLE next cycle.
REQ-028 SHALL otherwise enter EMIT with learned_valid=1 and done=1 for that first cycle, i.e. conflict_len+1 cycles after start.
REQ-029 SHALL hold learned_valid and all result outputs stable until learned_valid&&learned_ready, then return to IDLE.
REQ-030 SHALL keep result outputs stable in IDLE until the next accepted start.
REQ-031 SHALL clamp literal levels greater than the captured decision_level to decision_level.

Reset
REQ-032 SHALL on reset force IDLE with busy, learned_valid, done and unsat at 0, and learned_len, learned_clause and backtrack_level at 0, including mid-SCAN or mid-EMIT.
REQ-033 SHALL not accept start in the first cycle after reset deassertion.

Configuration
REQ-034 SHALL, with macro CAE_V2_DEDUP_EN defined, drop repeated identical literal values during SCAN, reducing learned_len; SCAN length stays conflict_len.
REQ-035 SHALL, without CAE_V2_DEDUP_EN, copy duplicates verbatim.

Structure
REQ-036 SHALL place the cae_state_e enum and the MAX_LITS, LEVEL_W and LIT_W defaults in satswarmv2_pkg.
REQ-037 SHALL keep the scan, tracking and emit logic in one module; no sub-module.

Verification
REQ-038 SHALL test lits {10@5, 11@3, 12@2}, dl=5, ready=1 -> clause {10,11,12}, len 3, bt 3, unsat 0, done 4 cycles after start.
REQ-039 SHALL test lits {20@2, 21@4, 22@1}, dl=4 -> clause[0]=21, then 20, 22; bt 2.
REQ-040 SHALL test lits {5@0, 6@0}, dl=0 -> unsat=1, done pulse, learned_valid=0, busy low one cycle later.
REQ-041 SHALL test Test-1 stimulus with learned_ready low for 5 cycles -> outputs stable and start ignored until handshake completes.
REQ-042 SHALL test lits {7@3, 7@3, 8@1}, dl=3 -> len 2 {7,8} with CAE_V2_DEDUP_EN defined; len 3 without it.
REQ-043 SHALL test reset asserted mid-SCAN -> immediate IDLE with all outputs 0, after which a fresh Test-1 run yields bt 3.
